// File: rtl/rv32i_multiplier_iterative_unit_pkg.sv
// Shared types and widths for the iterative multiplier: FSM states, operand/result widths.
package rv32i_multiplier_iterative_unit_pkg;

   localparam int MULT_OPERAND_WIDTH = 16;
   localparam int MULT_RESULT_WIDTH  = 32;

   typedef enum logic [1:0] {
      MulIdle = 2'd0,
      MulBusy = 2'd1,
      MulDone = 2'd2
   } mul_state_t;

   function automatic bit mult_bpc_legal(input int bpc);
      return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
   endfunction

endpackage

// File: rtl/rv32i_multiplier_iterative_unit_partial_step.sv
// One shift-add step: acc_out = acc_in + multiplicand * multiplier_bits (mod 2^32).
// Combinational, zero latency; no flow control.
import rv32i_multiplier_iterative_unit_pkg::*;

module rv32i_multiplier_iterative_unit_partial_step #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [MULT_RESULT_WIDTH-1:0] multiplicand,
   input  logic [BITS_PER_CYCLE-1:0]    multiplier_bits,
   input  logic [MULT_RESULT_WIDTH-1:0] acc_in,
   output logic [MULT_RESULT_WIDTH-1:0] acc_out
);

   logic [MULT_RESULT_WIDTH-1:0] bits_ext;
   logic [MULT_RESULT_WIDTH-1:0] partial;

   assign bits_ext = MULT_RESULT_WIDTH'(multiplier_bits);
   assign partial  = multiplicand * bits_ext;
   assign acc_out  = acc_in + partial;

endmodule

// File: rtl/rv32i_multiplier_iterative_unit.sv
// Iterative 16x16->32 shift-add multiplier, 16/BITS_PER_CYCLE cycles, result held until en drops.
// Define RV32I_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
import rv32i_multiplier_iterative_unit_pkg::*;

module rv32i_multiplier_iterative_unit #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_multiplier_en,
   input  logic [MULT_OPERAND_WIDTH-1:0] i_multiplier_operand_one,
   input  logic [MULT_OPERAND_WIDTH-1:0] i_multiplier_operand_two,
   output logic                          o_multiplier_valid,
   output logic [MULT_RESULT_WIDTH-1:0]  o_multiplier_result,
   output logic                          o_multiplier_busy
);

   localparam int N  = MULT_OPERAND_WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   generate
      if (!mult_bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
         $error("BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   mul_state_t                    state_q, state_d;
   logic [MULT_RESULT_WIDTH-1:0]  mcand_q, mcand_d;
   logic [MULT_OPERAND_WIDTH-1:0] mplier_q, mplier_d;
   logic [MULT_RESULT_WIDTH-1:0]  acc_q, acc_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [MULT_RESULT_WIDTH-1:0]  result_q, result_d;
   logic                          valid_q, valid_d;

   logic [MULT_RESULT_WIDTH-1:0]  acc_step;
   logic [MULT_OPERAND_WIDTH-1:0] mplier_shift;
   logic                          step_last;

   rv32i_multiplier_iterative_unit_partial_step #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .multiplicand    (mcand_q),
      .multiplier_bits (mplier_q[BITS_PER_CYCLE-1:0]),
      .acc_in          (acc_q),
      .acc_out         (acc_step)
   );

   assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef RV32I_MULT_EARLY_TERM_EN
   // Nothing left to add once the unconsumed multiplier bits are all zero.
   assign step_last = (cnt_q == CW'(1)) || (mplier_shift == '0);
`else
   assign step_last = (cnt_q == CW'(1));
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = 1'b0;
      case (state_q)
         MulIdle: begin
            if (i_multiplier_en) begin
               mcand_d  = MULT_RESULT_WIDTH'(i_multiplier_operand_one);
               mplier_d = i_multiplier_operand_two;
               acc_d    = '0;
               cnt_d    = CW'(N);
               state_d  = MulBusy;
            end
         end
         MulBusy: begin
            // Dropping en mid-operation abandons it; the previous result stays visible.
            if (!i_multiplier_en) begin
               state_d = MulIdle;
            end else begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << BITS_PER_CYCLE;
               mplier_d = mplier_shift;
               cnt_d    = cnt_q - CW'(1);
               if (step_last) begin
                  result_d = acc_step;
                  valid_d  = 1'b1;
                  state_d  = MulDone;
               end
            end
         end
         MulDone: begin
            if (!i_multiplier_en) begin
               state_d = MulIdle;
            end
         end
         default: state_d = MulIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= MulIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign o_multiplier_valid  = valid_q;
   assign o_multiplier_result = result_q;
   assign o_multiplier_busy   = (state_q != MulIdle);

endmodule

// File: tb/tb_rv32i_multiplier_iterative_unit.sv
// Directed bench for the iterative multiplier: one unit at 1 bit/cycle, one at 4 bits/cycle.
module tb_rv32i_multiplier_iterative_unit;

   logic        clk;
   logic        rst;
   logic        en_a    [2];
   logic [15:0] op1_a   [2];
   logic [15:0] op2_a   [2];
   logic        valid_a [2];
   logic [31:0] res_a   [2];
   logic        busy_a  [2];

   int compared;
   int mismatched;

   rv32i_multiplier_iterative_unit #(.BITS_PER_CYCLE(1)) dut1 (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_multiplier_en          (en_a[0]),
      .i_multiplier_operand_one (op1_a[0]),
      .i_multiplier_operand_two (op2_a[0]),
      .o_multiplier_valid       (valid_a[0]),
      .o_multiplier_result      (res_a[0]),
      .o_multiplier_busy        (busy_a[0])
   );

   rv32i_multiplier_iterative_unit #(.BITS_PER_CYCLE(4)) dut4 (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_multiplier_en          (en_a[1]),
      .i_multiplier_operand_one (op1_a[1]),
      .i_multiplier_operand_two (op2_a[1]),
      .o_multiplier_valid       (valid_a[1]),
      .o_multiplier_result      (res_a[1]),
      .o_multiplier_busy        (busy_a[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          unit;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_res;
      int          hold;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int lat_model(input logic [15:0] b, input int bpc);
`ifdef RV32I_MULT_EARLY_TERM_EN
      int hb;
      hb = -1;
      for (int i = 0; i < 16; i++) if (b[i]) hb = i;
      if (hb < 0) return 1;
      return (hb + bpc) / bpc;
`else
      if (b === 16'hxxxx) return 0;
      return 16 / bpc;
`endif
   endfunction

   // Request a multiply, measure latency from the capture edge, count pulses while en is held.
   task automatic do_mul(input int u, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_res, input int hold, input string nm);
      int lat, pulses, busy_bad, exp_lat, k;
      lat = -1; pulses = 0; busy_bad = 0; k = 0;
      exp_lat = lat_model(b, (u == 0) ? 1 : 4);
      @(negedge clk);
      en_a[u] = 1'b1; op1_a[u] = a; op2_a[u] = b;
      @(posedge clk);
      while (k < 40 && !(lat >= 0 && k >= lat + hold)) begin
         k++;
         @(posedge clk); #1;
         if (valid_a[u]) begin
            pulses++;
            if (lat < 0) lat = k;
         end
         if (!busy_a[u]) busy_bad++;
      end
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " result"}, res_a[u], exp_res);
      chk({nm, " pulses"}, pulses, 1);
      chk({nm, " busy"}, busy_bad, 0);
      @(negedge clk);
      en_a[u] = 1'b0;
      @(posedge clk); #1;
      chk({nm, " idle busy"}, {31'b0, busy_a[u]}, 32'd0);
   endtask

   initial begin
      compared = 0; mismatched = 0;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         en_a[u] = 1'b0; op1_a[u] = '0; op2_a[u] = '0;
      end

      vecs.push_back('{0, 16'h0003, 16'h0005, 32'h0000000F,  0, "basic"});
      vecs.push_back('{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 10, "max hold"});
      vecs.push_back('{0, 16'h8001, 16'h0002, 32'h00010002,  0, "after handshake"});
      vecs.push_back('{0, 16'h1234, 16'h0001, 32'h00001234,  0, "op2 one"});
      vecs.push_back('{0, 16'h0042, 16'h0000, 32'h00000000,  0, "op2 zero"});
      vecs.push_back('{0, 16'h00FF, 16'h0100, 32'h0000FF00,  0, "onehot 8"});
      vecs.push_back('{1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,  2, "bpc4 max"});
      vecs.push_back('{1, 16'h0003, 16'h0005, 32'h0000000F,  0, "bpc4 basic"});
      vecs.push_back('{1, 16'h00FF, 16'h0100, 32'h0000FF00,  0, "bpc4 onehot"});

      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("reset valid",  {31'b0, valid_a[u]}, 32'd0);
         chk("reset result", res_a[u], 32'd0);
         chk("reset busy",   {31'b0, busy_a[u]}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         do_mul(vecs[i].unit, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].hold, vecs[i].name);

      // Abort five edges into MulBusy; unit 0 last produced 0x0000FF00.
      begin
         int seen;
         seen = 0;
         @(negedge clk);
         en_a[0] = 1'b1; op1_a[0] = 16'h0007; op2_a[0] = 16'h8000;
         @(posedge clk);
         repeat (4) begin
            @(posedge clk); #1;
            if (valid_a[0]) seen++;
         end
         @(negedge clk);
         en_a[0] = 1'b0;
         @(posedge clk); #1;
         chk("abort busy", {31'b0, busy_a[0]}, 32'd0);
         chk("abort result", res_a[0], 32'h0000FF00);
         repeat (20) begin
            @(posedge clk); #1;
            if (valid_a[0]) seen++;
         end
         chk("abort no valid", seen, 0);
         chk("abort keeps result", res_a[0], 32'h0000FF00);
      end
      do_mul(0, 16'h0003, 16'h0005, 32'h0000000F, 0, "after abort");

      // Synchronous reset in the middle of MulBusy.
      @(negedge clk);
      en_a[0] = 1'b1; op1_a[0] = 16'h1111; op2_a[0] = 16'h8000;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst valid",  {31'b0, valid_a[0]}, 32'd0);
      chk("midrst result", res_a[0], 32'd0);
      chk("midrst busy",   {31'b0, busy_a[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b0; en_a[0] = 1'b0;
      do_mul(0, 16'h8001, 16'h0002, 32'h00010002, 0, "after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
